lfsr25_gen: RTL and testbench

- 25-bit Fibonacci LFSR random-word source for the LBM collision/noise path.
- Sits directly upstream of the bit-permuting scrambler stage and drives its 25-bit signed lfsr_out input.
- Adds seeding, zero-lock protection, post-seed warm-up, a configurable step stride between samples, and a valid/ready output handshake so consumers can stall it.

---
 rtl/lfsr_pkg.sv | 25 ++
 rtl/lfsr25_gen.sv | 93 +++++++++
 tb/tb_lfsr25_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Purpose : shared constants, state encoding and step function for the 25-bit LFSR source.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package lfsr_pkg;

  localparam int LFSR_W = 25;
  localparam int TAP_HI = 24;
  localparam int TAP_LO = 21;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 25'h1ACE1E5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    STEP   = 2'd3
  } state_t;

  // Fibonacci step for x^25 + x^22 + 1. A nonzero state never maps to zero,
  // so the generator cannot lock up once seeded with a nonzero value.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr25_gen.sv
// Purpose : 25-bit Fibonacci LFSR word source with seeding, warm-up and sample stride.
// Latency : seed to first valid word is WARMUP_CYCLES+1 edges; one word per cycle when STRIDE==1.
// Backpressure: out_ready low while out_valid holds lfsr_out and the LFSR state frozen.
//
// Ports:
//   Clk, Reset  - clock and asynchronous active-high reset
//   seed_load   - one-cycle seed request (highest priority, any state)
//   seed        - seed value, zero is replaced by DEFAULT_SEED
//   out_ready   - consumer takes lfsr_out this cycle
//   lfsr_out    - current LFSR word (always equals the state register)
//   out_valid   - lfsr_out is a valid sample (RUN state)
//   busy        - warm-up or stride stepping in progress
//   sample_cnt  - number of accepted samples, wraps at 2^32
module lfsr25_gen
  import lfsr_pkg::*;
#(
  parameter int                WARMUP_CYCLES = 32,
  parameter int                STRIDE        = 1,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT  = DEFAULT_SEED
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed,
  input  logic                     out_ready,
  output logic signed [LFSR_W-1:0] lfsr_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic [31:0]              sample_cnt
);

  localparam logic [31:0] WARMUP_LOAD = 32'(WARMUP_CYCLES);
  localparam logic [31:0] STRIDE_LOAD = 32'(STRIDE - 1);

  state_t            state;
  logic [LFSR_W-1:0] q;
  logic [31:0]       cnt;
  logic              accept;

  // A seed request in the same cycle as a handshake wins and drops the handshake.
  assign accept    = out_valid & out_ready & ~seed_load;

  assign out_valid = (state == RUN);
  assign busy      = (state == WARMUP) || (state == STEP);
  assign lfsr_out  = $signed(q);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      q          <= SEED_DEFAULT;
      cnt        <= '0;
      sample_cnt <= '0;
    end else if (seed_load) begin
      q <= (seed == '0) ? SEED_DEFAULT : seed;
      if (WARMUP_CYCLES == 0) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        state <= WARMUP;
        cnt   <= WARMUP_LOAD;
      end
    end else begin
      case (state)
        IDLE: begin
          // Unseeded: hold everything until the first seed request.
        end
        WARMUP, STEP: begin
          // Both count down one step per cycle; cnt==1 is the final step.
          q   <= lfsr_step(q);
          cnt <= cnt - 32'd1;
          if (cnt == 32'd1) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            q          <= lfsr_step(q);
            sample_cnt <= sample_cnt + 32'd1;
            // The accept itself is the first of STRIDE steps; the rest run in STEP.
            if (STRIDE > 1) begin
              state <= STEP;
              cnt   <= STRIDE_LOAD;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr25_gen.sv
// Purpose : directed self-checking bench for lfsr25_gen in three parameterisations.
// Latency : n/a.
// Backpressure: exercises stalls via out_ready.
module tb_lfsr25_gen;

  logic clk;
  logic rst;

  // Instance a: WARMUP_CYCLES=0, STRIDE=1
  logic        a_seed_load, a_ready, a_valid, a_busy;
  logic [24:0] a_seed, a_out;
  logic [31:0] a_cnt;
  // Instance b: WARMUP_CYCLES=4, STRIDE=1
  logic        b_seed_load, b_ready, b_valid, b_busy;
  logic [24:0] b_seed, b_out;
  logic [31:0] b_cnt;
  // Instance c: WARMUP_CYCLES=0, STRIDE=3
  logic        c_seed_load, c_ready, c_valid, c_busy;
  logic [24:0] c_seed, c_out;
  logic [31:0] c_cnt;

  int checks = 0;
  int errors = 0;

  lfsr25_gen #(.WARMUP_CYCLES(0), .STRIDE(1)) dut_a (
    .Clk(clk), .Reset(rst), .seed_load(a_seed_load), .seed(a_seed),
    .out_ready(a_ready), .lfsr_out(a_out), .out_valid(a_valid),
    .busy(a_busy), .sample_cnt(a_cnt)
  );

  lfsr25_gen #(.WARMUP_CYCLES(4), .STRIDE(1)) dut_b (
    .Clk(clk), .Reset(rst), .seed_load(b_seed_load), .seed(b_seed),
    .out_ready(b_ready), .lfsr_out(b_out), .out_valid(b_valid),
    .busy(b_busy), .sample_cnt(b_cnt)
  );

  lfsr25_gen #(.WARMUP_CYCLES(0), .STRIDE(3)) dut_c (
    .Clk(clk), .Reset(rst), .seed_load(c_seed_load), .seed(c_seed),
    .out_ready(c_ready), .lfsr_out(c_out), .out_valid(c_valid),
    .busy(c_busy), .sample_cnt(c_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_word;

    rst = 1'b1;
    a_seed_load = 1'b0; a_seed = '0; a_ready = 1'b0;
    b_seed_load = 1'b0; b_seed = '0; b_ready = 1'b0;
    c_seed_load = 1'b0; c_seed = '0; c_ready = 1'b0;
    #12;
    rst = 1'b0;

    // 1: unseeded after reset, nothing moves
    repeat (3) tick();
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_out",   {7'd0, a_out},    32'h01ACE1E5);
    chk("rst_cnt",   a_cnt,            32'd0);
    chk("rst_busy",  {31'd0, a_busy},  32'd0);

    // 2: no warm-up, stride 1, continuous ready
    a_seed_load = 1'b1; a_seed = 25'h0000001; a_ready = 1'b1;
    tick();
    a_seed_load = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      exp_word = (i <= 22) ? (32'd1 << (i - 1)) : 32'h00400001;
      chk("seq_valid", {31'd0, a_valid}, 32'd1);
      chk("seq_word",  {7'd0, a_out},    exp_word);
      chk("seq_cnt",   a_cnt,            32'(i - 1));
      tick();
    end
    a_ready = 1'b0;

    // 3: warm-up of 4 then stall
    b_seed_load = 1'b1; b_seed = 25'h0000001; b_ready = 1'b0;
    tick();
    b_seed_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wu_busy",  {31'd0, b_busy},  32'd1);
      chk("wu_valid", {31'd0, b_valid}, 32'd0);
      tick();
    end
    chk("wu_done_valid", {31'd0, b_valid}, 32'd1);
    chk("wu_done_busy",  {31'd0, b_busy},  32'd0);
    chk("wu_done_out",   {7'd0, b_out},    32'h00000010);
    repeat (5) begin
      tick();
      chk("stall_out", {7'd0, b_out}, 32'h00000010);
      chk("stall_cnt", b_cnt,         32'd0);
    end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("acc_cnt", b_cnt,         32'd1);
    chk("acc_out", {7'd0, b_out}, 32'h00000020);

    // 4: zero seed behaves as the default seed
    b_seed_load = 1'b1; b_seed = 25'h0;
    tick();
    b_seed_load = 1'b0;
    chk("zs_load", {7'd0, b_out}, 32'h01ACE1E5);
    repeat (4) tick();
    chk("zs_valid", {31'd0, b_valid}, 32'd1);
    chk("zs_out",   {7'd0, b_out},    32'h00CE1E56);
    chk("zs_cnt",   b_cnt,            32'd1);

    // 6a: reseed in the middle of warm-up restarts it
    b_seed_load = 1'b1; b_seed = 25'h0000001;
    tick();
    b_seed_load = 1'b0;
    repeat (2) tick();
    chk("mid_out",  {7'd0, b_out},   32'h00000004);
    chk("mid_busy", {31'd0, b_busy}, 32'd1);
    b_seed_load = 1'b1; b_seed = 25'h0000002;
    tick();
    b_seed_load = 1'b0;
    chk("reseed_out",  {7'd0, b_out},   32'h00000002);
    chk("reseed_busy", {31'd0, b_busy}, 32'd1);
    repeat (3) tick();
    chk("reseed_wait", {31'd0, b_valid}, 32'd0);
    tick();
    chk("reseed_valid", {31'd0, b_valid}, 32'd1);
    chk("reseed_word",  {7'd0, b_out},    32'h00000020);

    // 6b: seed request coincident with an accept drops the accept
    b_ready = 1'b1; b_seed_load = 1'b1; b_seed = 25'h0000001;
    tick();
    b_ready = 1'b0; b_seed_load = 1'b0;
    chk("coin_cnt",  b_cnt,           32'd1);
    chk("coin_out",  {7'd0, b_out},   32'h00000001);
    chk("coin_busy", {31'd0, b_busy}, 32'd1);

    // 5: stride 3, no warm-up
    c_seed_load = 1'b1; c_seed = 25'h0000001; c_ready = 1'b1;
    tick();
    c_seed_load = 1'b0;
    chk("st_v0",   {31'd0, c_valid}, 32'd1);
    chk("st_w0",   {7'd0, c_out},    32'h00000001);
    tick();
    chk("st_gap1", {31'd0, c_valid}, 32'd0);
    chk("st_busy", {31'd0, c_busy},  32'd1);
    chk("st_cnt1", c_cnt,            32'd1);
    tick();
    chk("st_gap2", {31'd0, c_valid}, 32'd0);
    tick();
    chk("st_v1",   {31'd0, c_valid}, 32'd1);
    chk("st_w1",   {7'd0, c_out},    32'h00000008);
    tick();
    chk("st_gap3", {31'd0, c_valid}, 32'd0);
    chk("st_cnt2", c_cnt,            32'd2);
    repeat (2) tick();
    chk("st_v2",   {31'd0, c_valid}, 32'd1);
    chk("st_w2",   {7'd0, c_out},    32'h00000040);

    // 6c: asynchronous reset while in STEP
    tick();
    chk("pre_rst_busy", {31'd0, c_busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, c_valid}, 32'd0);
    chk("arst_busy",  {31'd0, c_busy},  32'd0);
    chk("arst_out",   {7'd0, c_out},    32'h01ACE1E5);
    chk("arst_cnt",   c_cnt,            32'd0);
    rst = 1'b0;
    c_ready = 1'b0;
    repeat (2) tick();
    chk("post_rst_valid", {31'd0, c_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
